mem_gen_pipe: RTL

//  Parametrised successor to the generic simple-dual-port RAM: one write port, one read port.

---
 rtl/mem_gen_pkg.sv | 33 +++
 rtl/mem_gen_pipe_rd_pipe.sv | 44 ++++
 rtl/mem_gen_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_gen_pkg.sv
// Shared types and the byte-lane merge helper for the pipelined simple-dual-port RAM.
// Used by the write path and the WRITE_FIRST bypass so both always agree on lane semantics.
package mem_gen_pkg;

    typedef enum logic [0:0] {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Widest word / lane count the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_MAXW  = 512;
    localparam int MERGE_MAXBE = 512;

    function automatic logic [MERGE_MAXW-1:0] be_merge(
        input logic [MERGE_MAXW-1:0]  old_word,
        input logic [MERGE_MAXW-1:0]  new_word,
        input logic [MERGE_MAXBE-1:0] be,
        input int                     bytew
    );
        logic [MERGE_MAXW-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_MAXW; i++) begin
            if (be[i / bytew]) res[i] = new_word[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_gen_pipe_rd_pipe.sv
// Read-side delay line: RD_LAT-1 valid/data stages behind the array output register.
// Data stages load only on valid beats so the last stage holds the most recent result.
module mem_rd_pipe #(
    parameter int DATAW = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_thru
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_regs
            logic [DEPTH-1:0] v;
            logic [DATAW-1:0] d [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= '0;
                    for (int i = 0; i < DEPTH; i++) d[i] <= '0;
                end else begin
                    v[0] <= in_valid;
                    if (in_valid) d[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        v[i] <= v[i-1];
                        if (v[i-1]) d[i] <= d[i-1];
                    end
                end
            end

            assign out_valid = v[DEPTH-1];
            assign out_data  = d[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mem_gen_pipe.sv
// Simple-dual-port RAM with byte enables, RD_LAT-cycle read pipeline, selectable
// read-during-write behaviour and an optional post-reset clear engine.
module mem_gen_pipe
    import mem_gen_pkg::*;
#(
    parameter int               ADDRW      = 10,
    parameter int               DATAW      = 32,
    parameter int               BYTEW      = 8,
    parameter int               RD_LAT     = 1,
    parameter rdw_mode_e        RDW_MODE   = RDW_READ_FIRST,
    parameter bit               CLR_ON_RST = 1'b1,
    parameter logic [DATAW-1:0] CLR_VAL    = '0,
    localparam int              NBE        = DATAW / BYTEW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [NBE-1:0]   wr_be,
    input  logic [DATAW-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [DATAW-1:0] rd_data,
    output logic             rd_valid,
    output logic             init_busy
);

    generate
        if ((DATAW % BYTEW) != 0) begin : g_err_bytew
            $error("mem_gen_pipe: DATAW must be a multiple of BYTEW");
        end
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_err_lat
            $error("mem_gen_pipe: RD_LAT must be in 1..3");
        end
    endgenerate

    function automatic logic [DATAW-1:0] merge(
        input logic [DATAW-1:0] old_word,
        input logic [DATAW-1:0] new_word,
        input logic [NBE-1:0]   be
    );
        logic [MERGE_MAXW-1:0] res;
        res = be_merge(MERGE_MAXW'(old_word), MERGE_MAXW'(new_word), MERGE_MAXBE'(be), BYTEW);
        return res[DATAW-1:0];
    endfunction

    clr_state_e       clr_state;
    logic [ADDRW-1:0] clr_addr;
    logic [DATAW-1:0] ram [2**ADDRW];

    logic             wr_accept;
    logic             rd_accept;
    logic [DATAW-1:0] rd_word;
    logic             s1_valid;
    logic [DATAW-1:0] s1_data;

    assign init_busy = (clr_state == CLR_CLEAR);
    assign wr_accept = wr_en && !init_busy;
    assign rd_accept = rd_en && !init_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_state <= CLR_ON_RST ? CLR_CLEAR : CLR_IDLE;
            clr_addr  <= '0;
        end else if (clr_state == CLR_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) clr_state <= CLR_IDLE;
        end
    end

    // The array has no reset; only the clear engine or accepted writes touch it.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            ram[clr_addr] <= CLR_VAL;
        end else if (wr_accept && (|wr_be)) begin
            ram[wr_addr] <= merge(ram[wr_addr], wr_data, wr_be);
        end
    end

    always_comb begin
        rd_word = ram[rd_addr];
        if (RDW_MODE == RDW_WRITE_FIRST && wr_accept && (wr_addr == rd_addr)) begin
            rd_word = merge(rd_word, wr_data, wr_be);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) s1_data <= rd_word;
        end
    end

    mem_rd_pipe #(
        .DATAW (DATAW),
        .DEPTH (RD_LAT - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule
